// File: rtl/pulse_gen_1us_1ms_1s.sv
// Time-base generator: divides mclk into 1us/1ms/1s strobes and exports
// running usec/msec/sec counts for timestamping.
module pulse_gen_1us_1ms_1s #(
  parameter int unsigned SEC_W     = 32,
  // Ticks per ms and ms per s; 1000 in silicon, may be shrunk to exercise wraps.
  parameter int unsigned UNITS_PER = 1000
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             cfg_pulse_enb,
  input  logic             cfg_pulse_restart,
  input  logic [9:0]       cfg_pulse_1us,
  output logic             pulse_1us,
  output logic             pulse_1ms,
  output logic             pulse_1s,
  output logic [9:0]       cur_usec,
  output logic [9:0]       cur_msec,
  output logic [SEC_W-1:0] cur_sec
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UNITS_PER - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] cur_usec_q, cur_usec_d;
  logic [CNT_W-1:0] cur_msec_q, cur_msec_d;
  logic [SEC_W-1:0] cur_sec_q, cur_sec_d;
  logic             pulse_1us_q, pulse_1us_d;
  logic             pulse_1ms_q, pulse_1ms_d;
  logic             pulse_1s_q, pulse_1s_d;
  logic             hit_us_c, hit_ms_c, hit_s_c;

  // Divider compare and usec -> msec -> sec cascade; restart clears everything.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    cur_usec_d  = cur_usec_q;
    cur_msec_d  = cur_msec_q;
    cur_sec_d   = cur_sec_q;
    pulse_1us_d = 1'b0;
    pulse_1ms_d = 1'b0;
    pulse_1s_d  = 1'b0;

    // >= lets a lowered divisor wrap immediately instead of running to 1023.
    hit_us_c = cfg_pulse_enb & (div_cnt_q >= cfg_pulse_1us);
    hit_ms_c = hit_us_c & (cur_usec_q == LAST);
    hit_s_c  = hit_ms_c & (cur_msec_q == LAST);

    if (cfg_pulse_restart) begin
      div_cnt_d  = '0;
      cur_usec_d = '0;
      cur_msec_d = '0;
      cur_sec_d  = '0;
    end else begin
      if (hit_us_c) begin
        div_cnt_d  = '0;
        cur_usec_d = (cur_usec_q == LAST) ? '0 : cur_usec_q + CNT_W'(1);
      end else if (cfg_pulse_enb) begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
      if (hit_ms_c) begin
        cur_msec_d = (cur_msec_q == LAST) ? '0 : cur_msec_q + CNT_W'(1);
      end
      if (hit_s_c) begin
        cur_sec_d = cur_sec_q + SEC_W'(1);
      end
      pulse_1us_d = hit_us_c;
      pulse_1ms_d = hit_ms_c;
      pulse_1s_d  = hit_s_c;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge mclk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      cur_usec_q  <= '0;
      cur_msec_q  <= '0;
      cur_sec_q   <= '0;
      pulse_1us_q <= 1'b0;
      pulse_1ms_q <= 1'b0;
      pulse_1s_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      cur_usec_q  <= cur_usec_d;
      cur_msec_q  <= cur_msec_d;
      cur_sec_q   <= cur_sec_d;
      pulse_1us_q <= pulse_1us_d;
      pulse_1ms_q <= pulse_1ms_d;
      pulse_1s_q  <= pulse_1s_d;
    end
  end

  assign pulse_1us = pulse_1us_q;
  assign pulse_1ms = pulse_1ms_q;
  assign pulse_1s  = pulse_1s_q;
  assign cur_usec  = cur_usec_q;
  assign cur_msec  = cur_msec_q;
  assign cur_sec   = cur_sec_q;

endmodule

// File: tb/tb_pulse_gen_1us_1ms_1s.sv
// Self-checking bench: every cycle the DUT is compared against a model that
// tracks a total microsecond tick count and derives usec/msec/sec arithmetically.
module tb_pulse_gen_1us_1ms_1s;

  localparam int unsigned SEC_W = 2;
  localparam int unsigned U     = 20;   // shrunk units so seconds wrap in a short run

  logic             mclk = 1'b0;
  logic             reset;
  logic             cfg_pulse_enb;
  logic             cfg_pulse_restart;
  logic [9:0]       cfg_pulse_1us;
  logic             pulse_1us, pulse_1ms, pulse_1s;
  logic [9:0]       cur_usec, cur_msec;
  logic [SEC_W-1:0] cur_sec;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int     m_div   = 0;
  longint m_ticks = 0;
  bit     m_pulse = 1'b0;
  int     s_pulses = 0;

  pulse_gen_1us_1ms_1s #(.SEC_W(SEC_W), .UNITS_PER(U)) dut (
    .mclk              (mclk),
    .reset             (reset),
    .cfg_pulse_enb     (cfg_pulse_enb),
    .cfg_pulse_restart (cfg_pulse_restart),
    .cfg_pulse_1us     (cfg_pulse_1us),
    .pulse_1us         (pulse_1us),
    .pulse_1ms         (pulse_1ms),
    .pulse_1s          (pulse_1s),
    .cur_usec          (cur_usec),
    .cur_msec          (cur_msec),
    .cur_sec           (cur_sec)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, obs, exp);
    end
  endtask

  // One edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    longint e_ms, e_s;
    @(posedge mclk);
    if (reset || cfg_pulse_restart) begin
      m_div = 0; m_ticks = 0; m_pulse = 1'b0;
    end else if (cfg_pulse_enb) begin
      if (m_div >= int'(cfg_pulse_1us)) begin
        m_div = 0; m_ticks++; m_pulse = 1'b1;
      end else begin
        m_div++; m_pulse = 1'b0;
      end
    end else begin
      m_pulse = 1'b0;
    end
    #1;
    e_ms = (m_pulse && (m_ticks % U) == 0) ? 1 : 0;
    e_s  = (m_pulse && (m_ticks % (U * U)) == 0) ? 1 : 0;
    check("pulse_1us", longint'(pulse_1us), longint'(m_pulse));
    check("pulse_1ms", longint'(pulse_1ms), e_ms);
    check("pulse_1s",  longint'(pulse_1s),  e_s);
    check("cur_usec",  longint'(cur_usec),  m_ticks % U);
    check("cur_msec",  longint'(cur_msec),  (m_ticks / U) % U);
    check("cur_sec",   longint'(cur_sec),   (m_ticks / (U * U)) % (longint'(1) << SEC_W));
    if (pulse_1s) s_pulses++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    steps(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_pulse_enb = 1'b0; cfg_pulse_restart = 1'b0; cfg_pulse_1us = 10'd49;

    // Reset then basic divide-by-50
    do_reset(3);
    cfg_pulse_enb = 1'b1;
    steps(160);

    // Divisor shrink mid-count: 99 -> 19 at div_cnt=60
    cfg_pulse_1us = 10'd99;
    do_reset(1);
    steps(60);
    cfg_pulse_1us = 10'd19;
    steps(70);

    // Disable at div_cnt=5 for 40 cycles, then resume
    cfg_pulse_1us = 10'd9;
    do_reset(1);
    steps(25);
    cfg_pulse_enb = 1'b0;
    steps(40);
    cfg_pulse_enb = 1'b1;
    steps(30);

    // Restart colliding with a would-be hit
    cfg_pulse_1us = 10'd4;
    do_reset(1);
    steps(4);
    cfg_pulse_restart = 1'b1;
    step();
    cfg_pulse_restart = 1'b0;
    steps(20);

    // cfg=0 cascade through four seconds: sec counter wraps 3 -> 0
    cfg_pulse_1us = 10'd0;
    do_reset(1);
    s_pulses = 0;
    steps(4 * U * U);
    check("sec_pulse_count", longint'(s_pulses), 4);
    check("sec_wrapped", longint'(cur_sec), 0);

    // Randomized enable/restart/divisor/reset traffic
    cfg_pulse_1us = 10'd3;
    for (int i = 0; i < 12000; i++) begin
      cfg_pulse_enb     = ($urandom_range(0, 9) != 0);
      cfg_pulse_restart = ($urandom_range(0, 499) == 0);
      reset             = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 199) == 0) cfg_pulse_1us = 10'($urandom_range(0, 12));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
